// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse receiver: conditions the raw lines, decodes frames, assembles packets and
// accumulates a clamped absolute position. Define PS2_WHEEL_EN for 4-byte IntelliMouse packets.
module ps2_mouse_tracker #(
    parameter int X_MAX          = 1023,
    parameter int Y_MAX          = 767,
    parameter int X_INIT         = 512,
    parameter int Y_INIT         = 384,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 6500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        left_mouse,
    output logic        right_mouse,
    output logic        middle_mouse,
    output logic        packet_valid,
`ifdef PS2_WHEEL_EN
    output logic        frame_err,
    output logic [3:0]  wheel_delta
`else
    output logic        frame_err
`endif
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [13:0] X_MAX_W = 14'(X_MAX);
    localparam logic [13:0] Y_MAX_W = 14'(Y_MAX);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // 1 when the data byte plus its parity bit carry an odd number of ones
    function automatic logic odd_parity9(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    logic [1:0]     clk_sync_r;
    logic [1:0]     data_sync_r;
    logic [FCW-1:0] filt_cnt_r;
    logic           filt_r;
    logic           filt_d_r;
    logic           clk_s;
    logic           data_s;
    logic           strobe_s;
    logic [TW-1:0]  timer_r;
    logic           timeout_s;
    state_t         state_r;
    state_t         state_nxt_s;
    logic [2:0]     bit_cnt_r;
    logic [7:0]     shift_r;
    logic           parity_r;
    logic           stop_s;
    logic           byte_ok_s;
    logic           byte_err_s;
    logic [1:0]     byte_idx_r;
    logic [6:0]     hdr_r;      // {y_ovf, x_ovf, y_sign, x_sign, M, R, L}
    logic [7:0]     dx_byte_r;
    logic [7:0]     dy_byte_r;
    logic           pkt_ready_r;
    logic [13:0]    dx_s;
    logic [13:0]    dy_s;
    logic [13:0]    x_sum_s;
    logic [13:0]    y_sum_s;
    logic [11:0]    x_new_s;
    logic [11:0]    y_new_s;
    logic [11:0]    xpos_r;
    logic [11:0]    ypos_r;
    logic [2:0]     btn_r;
    logic           packet_valid_r;
    logic           frame_err_r;
`ifdef PS2_WHEEL_EN
    logic [3:0]     wheel_byte_r;
    logic [3:0]     wheel_delta_r;
`endif

    assign clk_s    = clk_sync_r[1];
    assign data_s   = data_sync_r[1];
    assign strobe_s = filt_d_r & ~filt_r;

    // two-flop synchronisers; idle bus level is high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_r  <= 2'b11;
            data_sync_r <= 2'b11;
        end else begin
            clk_sync_r  <= {clk_sync_r[0], ps2_clk};
            data_sync_r <= {data_sync_r[0], ps2_data};
        end
    end

    // glitch filter: a new clock level is accepted after FILTER_LEN consecutive samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_cnt_r <= '0;
            filt_r     <= 1'b1;
            filt_d_r   <= 1'b1;
        end else begin
            filt_d_r <= filt_r;
            if (clk_s == filt_r) begin
                filt_cnt_r <= '0;
            end else if (filt_cnt_r == FCW'(FILTER_LEN - 1)) begin
                filt_r     <= clk_s;
                filt_cnt_r <= '0;
            end else begin
                filt_cnt_r <= filt_cnt_r + FCW'(1);
            end
        end
    end

    // idle timer since the last strobe, saturating at the timeout value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_r <= '0;
        end else if (strobe_s) begin
            timer_r <= '0;
        end else if (timer_r != TW'(TIMEOUT_CYCLES)) begin
            timer_r <= timer_r + TW'(1);
        end else begin
            timer_r <= timer_r;
        end
    end

    // fires once, in the cycle the timer reaches its limit
    assign timeout_s = !strobe_s && (timer_r == TW'(TIMEOUT_CYCLES - 1));

    // frame state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // frame next-state logic, advanced only on the sample strobe
    always_comb begin
        state_nxt_s = state_r;
        if (timeout_s) begin
            state_nxt_s = ST_IDLE;
        end else if (strobe_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (!data_s) begin
                        state_nxt_s = ST_DATA;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (bit_cnt_r == 3'd7) begin
                        state_nxt_s = ST_PARITY;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end
                ST_PARITY: state_nxt_s = ST_STOP;
                ST_STOP:   state_nxt_s = ST_IDLE;
                default:   state_nxt_s = ST_IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // bit shifter, LSB first, plus parity capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'd0;
            parity_r  <= 1'b0;
        end else if (strobe_s) begin
            case (state_r)
                ST_IDLE:   bit_cnt_r <= 3'd0;
                ST_DATA: begin
                    shift_r   <= {data_s, shift_r[7:1]};
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                end
                ST_PARITY: parity_r <= data_s;
                default:   bit_cnt_r <= bit_cnt_r;
            endcase
        end else begin
            bit_cnt_r <= bit_cnt_r;
        end
    end

    assign stop_s     = strobe_s && (state_r == ST_STOP);
    assign byte_ok_s  = stop_s && data_s && odd_parity9(shift_r, parity_r);
    assign byte_err_s = stop_s && !(data_s && odd_parity9(shift_r, parity_r));

    // packet assembly; a header without bit3 set is dropped to regain alignment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx_r  <= 2'd0;
            hdr_r       <= 7'd0;
            dx_byte_r   <= 8'd0;
            dy_byte_r   <= 8'd0;
            pkt_ready_r <= 1'b0;
`ifdef PS2_WHEEL_EN
            wheel_byte_r <= 4'd0;
`endif
        end else begin
            pkt_ready_r <= 1'b0;
            if (byte_err_s || timeout_s) begin
                byte_idx_r <= 2'd0;
            end else if (byte_ok_s) begin
                case (byte_idx_r)
                    2'd0: begin
                        if (shift_r[3]) begin
                            hdr_r      <= {shift_r[7:4], shift_r[2:0]};
                            byte_idx_r <= 2'd1;
                        end else begin
                            byte_idx_r <= 2'd0;
                        end
                    end
                    2'd1: begin
                        dx_byte_r  <= shift_r;
                        byte_idx_r <= 2'd2;
                    end
                    2'd2: begin
                        dy_byte_r <= shift_r;
`ifdef PS2_WHEEL_EN
                        byte_idx_r <= 2'd3;
`else
                        byte_idx_r  <= 2'd0;
                        pkt_ready_r <= 1'b1;
`endif
                    end
                    default: begin
`ifdef PS2_WHEEL_EN
                        wheel_byte_r <= shift_r[3:0];
                        pkt_ready_r  <= 1'b1;
`endif
                        byte_idx_r <= 2'd0;
                    end
                endcase
            end else begin
                byte_idx_r <= byte_idx_r;
            end
        end
    end

    // 9-bit deltas sign-extended to 14 bits; an overflowed axis contributes nothing
    assign dx_s    = hdr_r[5] ? 14'd0 : {{6{hdr_r[3]}}, dx_byte_r};
    assign dy_s    = hdr_r[6] ? 14'd0 : {{6{hdr_r[4]}}, dy_byte_r};
    assign x_sum_s = {2'b00, xpos_r} + dx_s;
    assign y_sum_s = {2'b00, ypos_r} - dy_s;

    // clamp both axes to the visible range
    always_comb begin
        x_new_s = x_sum_s[11:0];
        y_new_s = y_sum_s[11:0];
        if (x_sum_s[13]) begin
            x_new_s = 12'd0;
        end else if (x_sum_s > X_MAX_W) begin
            x_new_s = X_MAX_W[11:0];
        end else begin
            x_new_s = x_sum_s[11:0];
        end
        if (y_sum_s[13]) begin
            y_new_s = 12'd0;
        end else if (y_sum_s > Y_MAX_W) begin
            y_new_s = Y_MAX_W[11:0];
        end else begin
            y_new_s = y_sum_s[11:0];
        end
    end

    // registered outputs and status pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xpos_r         <= 12'(X_INIT);
            ypos_r         <= 12'(Y_INIT);
            btn_r          <= 3'd0;
            packet_valid_r <= 1'b0;
            frame_err_r    <= 1'b0;
`ifdef PS2_WHEEL_EN
            wheel_delta_r  <= 4'd0;
`endif
        end else begin
            packet_valid_r <= pkt_ready_r;
            frame_err_r    <= byte_err_s || (timeout_s && (state_r != ST_IDLE));
            if (pkt_ready_r) begin
                xpos_r <= x_new_s;
                ypos_r <= y_new_s;
                btn_r  <= hdr_r[2:0];
`ifdef PS2_WHEEL_EN
                wheel_delta_r <= wheel_byte_r;
`endif
            end else begin
                xpos_r <= xpos_r;
            end
        end
    end

    assign xpos         = xpos_r;
    assign ypos         = ypos_r;
    assign left_mouse   = btn_r[0];
    assign right_mouse  = btn_r[1];
    assign middle_mouse = btn_r[2];
    assign packet_valid = packet_valid_r;
    assign frame_err    = frame_err_r;
`ifdef PS2_WHEEL_EN
    assign wheel_delta  = wheel_delta_r;
`endif

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Self-checking bench for ps2_mouse_tracker: directed packet table, error/timeout/reset
// sequences, and randomized packets checked against an integer position model.
module tb_ps2_mouse_tracker;

    localparam int HALF    = 20;
    localparam int GAP     = 20;
    localparam int TIMEOUT = 6500;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [11:0] xpos, ypos;
    logic        left_mouse, right_mouse, middle_mouse, packet_valid, frame_err;
`ifdef PS2_WHEEL_EN
    logic [3:0]  wheel_delta;
    logic [3:0]  cap_w;
`endif

    ps2_mouse_tracker dut (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .xpos         (xpos),
        .ypos         (ypos),
        .left_mouse   (left_mouse),
        .right_mouse  (right_mouse),
        .middle_mouse (middle_mouse),
        .packet_valid (packet_valid),
`ifdef PS2_WHEEL_EN
        .frame_err    (frame_err),
        .wheel_delta  (wheel_delta)
`else
        .frame_err    (frame_err)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int pv_cnt = 0, fe_cnt = 0, spur = 0, pv_long = 0, fe_long = 0, both = 0;
    logic [11:0] cap_x, cap_y, prev_x, prev_y;
    logic [2:0]  cap_btn, prev_btn;
    logic        pv_prev = 1'b0, fe_prev = 1'b0;

    // output monitor: captures each packet and counts pulse anomalies
    always @(negedge clk) begin
        if (!rst) begin
            pv_prev  <= 1'b0;
            fe_prev  <= 1'b0;
        end else begin
            if (packet_valid) begin
                pv_cnt  <= pv_cnt + 1;
                cap_x   <= xpos;
                cap_y   <= ypos;
                cap_btn <= {middle_mouse, right_mouse, left_mouse};
`ifdef PS2_WHEEL_EN
                cap_w   <= wheel_delta;
`endif
                if (pv_prev) pv_long <= pv_long + 1;
                if (frame_err) both <= both + 1;
            end else if (xpos != prev_x || ypos != prev_y ||
                         {middle_mouse, right_mouse, left_mouse} != prev_btn) begin
                spur <= spur + 1;
            end
            if (frame_err) begin
                fe_cnt <= fe_cnt + 1;
                if (fe_prev) fe_long <= fe_long + 1;
            end
            pv_prev <= packet_valid;
            fe_prev <= frame_err;
        end
        prev_x   <= xpos;
        prev_y   <= ypos;
        prev_btn <= {middle_mouse, right_mouse, left_mouse};
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(1'b1);
        repeat (GAP) @(posedge clk);
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0, 1'b0);
        send_byte(b1, 1'b0);
        send_byte(b2, 1'b0);
`ifdef PS2_WHEEL_EN
        send_byte(b3, 1'b0);
`endif
    endtask

    task automatic wait_pv(input int target);
        int n;
        n = 0;
        while (pv_cnt < target && n < 300) begin
            @(posedge clk);
            n++;
        end
        repeat (5) @(posedge clk);
    endtask

    task automatic check_pkt(input string name, input int pv0, input int ex, input int ey,
                             input logic [2:0] eb);
        wait_pv(pv0 + 1);
        check({name, "_pv"}, pv_cnt - pv0, 1);
        check({name, "_x"}, int'(cap_x), ex);
        check({name, "_y"}, int'(cap_y), ey);
        check({name, "_btn"}, int'(cap_btn), int'(eb));
        check({name, "_xhold"}, int'(xpos), ex);
    endtask

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int delta(input logic sign, input logic [7:0] b);
        return sign ? int'(b) - 256 : int'(b);
    endfunction

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         ex, ey;
        logic [2:0] eb;
    } vec_t;

    vec_t tbl[18];
    int   mx, my, pv0, fe0, waited;
    logic [7:0] r0, r1, r2, r3;

    initial begin
        tbl[0]  = '{8'h09, 8'h05, 8'h03,  517, 381, 3'b001};
        tbl[1]  = '{8'h08, 8'hFF, 8'h00,  772, 381, 3'b000};
        tbl[2]  = '{8'h08, 8'hF8, 8'h00, 1020, 381, 3'b000};
        tbl[3]  = '{8'h08, 8'h10, 8'h00, 1023, 381, 3'b000};
        tbl[4]  = '{8'h18, 8'hE0, 8'h00,  991, 381, 3'b000};
        tbl[5]  = '{8'h08, 8'h00, 8'hFF,  991, 126, 3'b000};
        tbl[6]  = '{8'h08, 8'h00, 8'hFF,  991,   0, 3'b000};
        tbl[7]  = '{8'h28, 8'h00, 8'h00,  991, 256, 3'b000};
        tbl[8]  = '{8'h28, 8'h00, 8'h00,  991, 512, 3'b000};
        tbl[9]  = '{8'h28, 8'h00, 8'h00,  991, 767, 3'b000};
        tbl[10] = '{8'h18, 8'h00, 8'h00,  735, 767, 3'b000};
        tbl[11] = '{8'h18, 8'h00, 8'h00,  479, 767, 3'b000};
        tbl[12] = '{8'h18, 8'h00, 8'h00,  223, 767, 3'b000};
        tbl[13] = '{8'h18, 8'h00, 8'h00,    0, 767, 3'b000};
        tbl[14] = '{8'h48, 8'h7F, 8'h01,    0, 766, 3'b000};
        tbl[15] = '{8'h0F, 8'h01, 8'hFF,    1, 511, 3'b111};
        tbl[16] = '{8'h3C, 8'h00, 8'h00,    0, 767, 3'b100};
        tbl[17] = '{8'h88, 8'h01, 8'h01,    1, 767, 3'b000};

        // reset state
        repeat (5) @(posedge clk);
        #1;
        check("rst_x", int'(xpos), 512);
        check("rst_y", int'(ypos), 384);
        check("rst_btn", int'({middle_mouse, right_mouse, left_mouse}), 0);
        check("rst_pv", int'(packet_valid), 0);
        check("rst_fe", int'(frame_err), 0);
        @(negedge clk) rst = 1'b1;
        repeat (20) @(posedge clk);

        // directed packet table
        for (int i = 0; i < 18; i++) begin
            pv0 = pv_cnt;
            send_packet(tbl[i].b0, tbl[i].b1, tbl[i].b2, 8'h00);
            check_pkt($sformatf("tbl%0d", i), pv0, tbl[i].ex, tbl[i].ey, tbl[i].eb);
        end

        // header without bit3 is dropped
        pv0 = pv_cnt;
        send_byte(8'h01, 1'b0);
        send_packet(8'h0A, 8'h00, 8'h00, 8'h00);
        check_pkt("resync", pv0, 1, 767, 3'b010);

        // parity error, then a clean packet
        pv0 = pv_cnt;
        fe0 = fe_cnt;
        send_byte(8'h0C, 1'b1);
        repeat (50) @(posedge clk);
        check("parity_fe", fe_cnt - fe0, 1);
        check("parity_nopv", pv_cnt - pv0, 0);
        send_packet(8'h09, 8'h02, 8'h00, 8'h00);
        check_pkt("after_parity", pv0, 3, 767, 3'b001);

        // mid-frame timeout
        pv0 = pv_cnt;
        fe0 = fe_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        waited = 0;
        while (fe_cnt == fe0 && waited < TIMEOUT + 500) begin
            @(posedge clk);
            waited++;
        end
        repeat (20) @(posedge clk);
        check("timeout_fe", fe_cnt - fe0, 1);
        check("timeout_not_early", int'(waited > TIMEOUT - 100), 1);
        check("timeout_nopv", pv_cnt - pv0, 0);
        send_packet(8'h08, 8'h00, 8'h01, 8'h00);
        check_pkt("after_timeout", pv0, 3, 766, 3'b000);

        // randomized packets against the position model
        mx = 3;
        my = 766;
        for (int i = 0; i < 10; i++) begin
            r0 = 8'($urandom) | 8'h08;
            r1 = 8'($urandom);
            r2 = 8'($urandom);
            r3 = 8'($urandom);
            if (!r0[6]) mx = clampi(mx + delta(r0[4], r1), 1023);
            if (!r0[7]) my = clampi(my - delta(r0[5], r2), 767);
            pv0 = pv_cnt;
            send_packet(r0, r1, r2, r3);
            check_pkt($sformatf("rand%0d", i), pv0, mx, my, r0[2:0]);
`ifdef PS2_WHEEL_EN
            check($sformatf("rand%0d_wheel", i), int'(cap_w), int'(r3[3:0]));
`endif
        end

        // reset in the middle of a byte
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        @(negedge clk) rst = 1'b0;
        #1;
        check("midrst_x", int'(xpos), 512);
        check("midrst_y", int'(ypos), 384);
        check("midrst_btn", int'({middle_mouse, right_mouse, left_mouse}), 0);
        check("midrst_pv", int'(packet_valid), 0);
        check("midrst_fe", int'(frame_err), 0);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (20) @(posedge clk);
        pv0 = pv_cnt;
        send_packet(8'h09, 8'h05, 8'h03, 8'h00);
        check_pkt("after_rst", pv0, 517, 381, 3'b001);

        // pulse-shape and no-change-without-valid properties
        check("spurious_change", spur, 0);
        check("pv_one_cycle", pv_long, 0);
        check("fe_one_cycle", fe_long, 0);
        check("pv_fe_overlap", both, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_tracker.md
Name: ps2_mouse_tracker

Overview:
- Producer end of the mouse interface consumed by the oscilloscope user-interface logic.
- Receives raw PS/2 device-to-host frames, assembles 3-byte mouse packets, and accumulates an absolute clamped screen position.
- Outputs 12-bit xpos/ypos and left/right/middle button levels, all in the pixel clock domain.

Parameters:
- X_MAX, 1023, maximum xpos value (inclusive clamp limit).
- Y_MAX, 767, maximum ypos value (inclusive clamp limit).
- X_INIT, 512, xpos value after reset.
- Y_INIT, 384, ypos value after reset.
- FILTER_LEN, 8, number of consecutive equal samples required to accept a new ps2_clk level.
- TIMEOUT_CYCLES, 6500, idle clk cycles since the last ps2_clk falling edge before the receiver resynchronises.

Ports:
- clk  input  1  system clock; all logic is in this single domain.
- rst  input  1  asynchronous active-low reset; the block is in reset while rst=0.
- ps2_clk  input  1  raw PS/2 clock from the device, asynchronous.
- ps2_data  input  1  raw PS/2 data from the device, asynchronous.
- xpos  output  12  absolute X position, in the range 0..X_MAX.
- ypos  output  12  absolute Y position, in the range 0..Y_MAX; 0 is the top of the screen.
- left_mouse  output  1  left button level.
- right_mouse  output  1  right button level.
- middle_mouse  output  1  middle button level.
- packet_valid  output  1  one-cycle pulse, asserted in the cycle the outputs take a new packet's values.
- frame_err  output  1  one-cycle pulse on a parity error, a stop-bit error, or a mid-frame timeout.

Behaviour:
- Reset values: xpos=X_INIT, ypos=Y_INIT; buttons, packet_valid and frame_err all 0; FSM in IDLE; bit count, byte index and timer all 0.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchroniser.
  - ps2_clk is additionally filtered by FILTER_LEN consecutive equal samples.
  - A falling edge of the filtered clock is the sample strobe; ps2_data (synchronised) is sampled on that strobe.
- Frame FSM, advanced only on the sample strobe:
  - IDLE: data=0 -> DATA with bit count cleared; data=1 -> stay in IDLE (glitch ignored).
  - DATA: shift the sampled bit in LSB first; after 8 bits -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: if stop=1 and the 9 bits {data, parity} have odd parity, the byte is accepted; otherwise frame_err pulses and the byte index is cleared. Either way -> IDLE.
- Timeout:
  - The timer clears on every strobe and saturates at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES: FSM -> IDLE and byte index -> 0.
  - frame_err pulses only if the FSM was not in IDLE at that moment.
- Packet assembly:
  - Byte 0 is accepted only if bit3=1; otherwise it is discarded and the byte index stays 0 (resync).
  - Byte 0 fields: bit0 L, bit1 R, bit2 M, bit4 X sign, bit5 Y sign, bit6 X overflow, bit7 Y overflow.
  - Byte 1 is dx[7:0] and byte 2 is dy[7:0]; each delta is the 9-bit two's complement {sign, byte}.
- Update timing:
  - The stop bit of byte 2 is sampled in cycle N.
  - In cycle N+1 the packet is complete; in cycle N+2 xpos, ypos and the buttons take their new values and packet_valid=1 for exactly that cycle.
- Arithmetic:
  - x_new = xpos + dx, computed as 14-bit signed.
  - y_new = ypos - dy (PS/2 +Y is up; the screen Y axis is down).
  - Results below 0 clamp to 0; results above X_MAX/Y_MAX clamp to X_MAX/Y_MAX.
  - If an overflow bit is set, that axis's delta is treated as 0. The buttons still update and packet_valid still pulses.
- Simultaneous events:
  - Reset dominates everything.
  - A timeout and a strobe never coincide, because the strobe clears the timer.
  - frame_err and packet_valid never assert in the same cycle.
- Reset mid-frame: the partial byte and packet are discarded; the next start bit begins a new byte 0.

Optional Feature:
- Macro: PS2_WHEEL_EN.
- Defined:
  - Packets are 4 bytes (IntelliMouse). Byte 3[3:0] is a signed scroll delta.
  - An extra output wheel_delta (4 bits, signed) is registered alongside packet_valid. It holds the latest packet's delta and resets to 0.
  - The update occurs 2 cycles after byte 3's stop bit.
- Not defined: 3-byte packets only, and the wheel_delta port is absent.

Test Plan:
- Reset -> xpos=512, ypos=384, buttons=0. Then send packet 0x09, 0x05, 0x03 -> 2 cycles after the last stop bit: xpos=517, ypos=381, left_mouse=1, packet_valid pulses once.
- From xpos=1020 send 0x08, 0x10, 0x00 (dx=+16) -> xpos=1023 (clamped). Then send 0x18, 0xE0, 0x00 (dx=-32) -> xpos=991.
- Send byte 0 with bit3=0 (0x01), then a valid 0x0A, 0x00, 0x00 -> the first byte is dropped and one packet is decoded with right_mouse=1 and position unchanged.
- Send byte 0x0C with even parity -> frame_err pulses, no packet_valid. The following valid 3-byte packet then decodes correctly.
- After start plus 4 data bits, hold ps2_clk high for TIMEOUT_CYCLES -> frame_err pulses once and the FSM returns to IDLE. The next full packet decodes.
- Send 0x48, 0x7F, 0x01 (X overflow set) -> xpos unchanged, ypos decreases by 1, packet_valid pulses. Drive rst=0 mid-byte -> outputs return to their reset values immediately.
